// File: rtl/lpif_rx_byte_packer.sv
// lpif_rx_byte_packer
// RX-side LPIF byte packer. It compacts the valid input bytes toward lane 0
// and appends them to a shift-based accumulator of 2*LANES-1 entries. Each
// entry holds a byte and its five framing flags. The packer emits densely
// packed beats: a full beat whenever at least LANES bytes are available, and
// a partial beat on idle timeout. The LTSSM sideband is registered onto the
// LPIF.
// Optional feature macro: LPIF_RX_EOP_FLUSH_EN. When it is defined, a partial
// beat is also released up to the last end-of-packet marker (tlpend, dllpend
// or edb).
module lpif_rx_byte_packer #(
  parameter int LANES        = 64,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*LANES-1:0]     packetData,
  input  logic [LANES-1:0]       packetValid,
  input  logic [LANES-1:0]       tlpstart,
  input  logic [LANES-1:0]       tlpend,
  input  logic [LANES-1:0]       edb,
  input  logic [LANES-1:0]       dllpstart,
  input  logic [LANES-1:0]       dllpend,
  input  logic                   lp_force_detect,
  input  logic [2:0]             GEN,
  input  logic [3:0]             state,
  output logic [8*LANES-1:0]     pl_data,
  output logic [LANES-1:0]       pl_valid,
  output logic [LANES-1:0]       pl_tlpstart,
  output logic [LANES-1:0]       pl_tlpend,
  output logic [LANES-1:0]       pl_tlpedb,
  output logic [LANES-1:0]       pl_dllpstart,
  output logic [LANES-1:0]       pl_dllpend,
  output logic [2:0]             pl_speedmode,
  output logic [3:0]             pl_state_sts,
  output logic                   ltssmForceDetect,
  output logic [$clog2(2*LANES)-1:0] pack_level
);

  localparam int ACC = 2*LANES - 1;
  localparam int CW  = $clog2(2*LANES);
  localparam int EW  = 13;  // {dllpend, dllpstart, edb, tlpend, tlpstart, data[7:0]}
  localparam int IW  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  logic [EW-1:0] acc_reg  [ACC];
  logic [EW-1:0] acc_next [ACC];
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0] idle_reg, idle_next;

  logic [EW-1:0] in_entry  [LANES];
  logic [EW-1:0] merged    [ACC];
  logic [CW-1:0] merge_pos;
  logic [CW-1:0] m;

  logic [EW-1:0] out_reg  [LANES];
  logic [EW-1:0] out_next [LANES];
  logic [LANES-1:0] valid_reg, valid_next;

  logic [2:0] speed_reg, speed_next;
  logic [3:0] state_reg;
  logic       force_reg;

  logic [CW-1:0] n;
  logic [CW-1:0] eop_n;
  logic [IW-1:0] idle_view;
  logic          timeout_hit;
  logic [CW:0]   src_idx;

  // Bundle each input lane's byte with its framing flags.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_in
      assign in_entry[gi] = {dllpend[gi], dllpstart[gi], edb[gi], tlpend[gi],
                             tlpstart[gi], packetData[8*gi +: 8]};
    end
  endgenerate

  // Merged view: the held bytes, followed by this cycle's compacted valid bytes.
  always_comb begin
    for (int j = 0; j < ACC; j++) begin
      merged[j] = (CW'(j) < cnt_reg) ? acc_reg[j] : '0;
    end
    merge_pos = cnt_reg;
    for (int k = 0; k < LANES; k++) begin
      if (packetValid[k]) begin
        merged[merge_pos] = in_entry[k];
        merge_pos         = merge_pos + CW'(1);
      end
    end
    m = merge_pos;
  end

  // Emit decision, output lane selection and left-shift of the remainder.
  always_comb begin
    // The idle count includes the current cycle, so the flush lands on the
    // IDLE_TIMEOUT-th consecutive idle cycle.
    if (IDLE_TIMEOUT == 0 || packetValid != '0)
      idle_view = '0;
    else if (idle_reg == IW'(IDLE_TIMEOUT))
      idle_view = idle_reg;
    else
      idle_view = idle_reg + IW'(1);
    timeout_hit = (IDLE_TIMEOUT != 0) && (idle_view == IW'(IDLE_TIMEOUT));

    eop_n = '0;
`ifdef LPIF_RX_EOP_FLUSH_EN
    for (int j = 0; j < ACC; j++) begin
      if (CW'(j) < m && (merged[j][9] || merged[j][10] || merged[j][12]))
        eop_n = CW'(j + 1);
    end
`endif

    n = '0;
    if (lp_force_detect)
      n = '0;
    else if (m >= CW'(LANES))
      n = CW'(LANES);
    else if (eop_n != '0)
      n = eop_n;
    else if (timeout_hit && m != '0)
      n = m;

    if (lp_force_detect) begin
      cnt_next  = '0;
      idle_next = '0;
    end else begin
      cnt_next  = m - n;
      idle_next = (n != '0) ? '0 : idle_view;
    end

    for (int j = 0; j < LANES; j++) begin
      valid_next[j] = (CW'(j) < n);
      out_next[j]   = (CW'(j) < n) ? merged[j] : '0;
    end

    src_idx = '0;
    for (int j = 0; j < ACC; j++) begin
      src_idx = {1'b0, CW'(j)} + {1'b0, n};
      if (src_idx < {1'b0, m})
        acc_next[j] = merged[src_idx[CW-1:0]];
      else
        acc_next[j] = '0;
    end
  end

  // Generation to speed-mode code; out-of-range generations map to all ones.
  always_comb begin
    speed_next = 3'b111;
    if (GEN >= 3'd1 && GEN <= 3'd5)
      speed_next = GEN - 3'd1;
  end

  // State, output and sideband registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      idle_reg  <= '0;
      valid_reg <= '0;
      speed_reg <= 3'b111;
      state_reg <= '0;
      force_reg <= 1'b0;
      for (int j = 0; j < ACC; j++) acc_reg[j] <= '0;
      for (int j = 0; j < LANES; j++) out_reg[j] <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      idle_reg  <= idle_next;
      valid_reg <= valid_next;
      speed_reg <= speed_next;
      state_reg <= state;
      force_reg <= lp_force_detect;
      for (int j = 0; j < ACC; j++) acc_reg[j] <= acc_next[j];
      for (int j = 0; j < LANES; j++) out_reg[j] <= out_next[j];
    end
  end

  // Unpack registered entries onto the LPIF lanes.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_out
      assign pl_data[8*gi +: 8] = out_reg[gi][7:0];
      assign pl_tlpstart[gi]    = out_reg[gi][8];
      assign pl_tlpend[gi]      = out_reg[gi][9];
      assign pl_tlpedb[gi]      = out_reg[gi][10];
      assign pl_dllpstart[gi]   = out_reg[gi][11];
      assign pl_dllpend[gi]     = out_reg[gi][12];
    end
  endgenerate

  assign pl_valid         = valid_reg;
  assign pl_speedmode     = speed_reg;
  assign pl_state_sts     = state_reg;
  assign ltssmForceDetect = force_reg;
  assign pack_level       = cnt_reg;

endmodule
